bp_train_sched: RTL
===================

// Module: bp_train_sched
// PURPOSE
//  Training-port scheduler for the global and local CBP predictor tables.
//  - After reset or flush: sweeps every table index, one write per cycle, with an init command.
//  - Otherwise: buffers MD-stage commit training requests in a FIFO and drains one per cycle onto the single table write port.
//  - Gates fetch-side predictions until init completes; keeps commit/mispredict statistics.
// PARAMETERS
//  IDX_W       7    table index / history width
//  TBL_DEPTH   128  entries swept during init (= 2**IDX_W)
//  FIFO_DEPTH  4    commit-request buffer depth (power of 2, >=2)
//  CNT_W       32   statistics counter width
// PORTS
//  clk_i          in   1      clock, all state updates on rising edge
//  rst_n          in   1      reset, synchronous, active-low
//  flush_i        in   1      re-initialise tables (discard buffered training)
//  md_valid_i     in   1      commit training request
//  md_ready_o     out  1      request accepted when md_valid_i & md_ready_o
//  md_idx_i       in   IDX_W  committing branch PC index
//  md_hist_i      in   IDX_W  global history captured at prediction
//  md_pred_i      in   1      direction predicted at fetch
//  md_correct_i   in   1      1 = prediction was correct
//  wr_valid_o     out  1      table write strobe (registered)
//  wr_init_o      out  1      1 = init write (PHT<=2'b01, BHT<=0) at wr_idx_o
//  wr_idx_o       out  IDX_W  write index / PC index
//  wr_hist_o      out  IDX_W  history for PHT hash (0 during init)
//  wr_pred_o      out  1      predicted direction of training entry
//  wr_correct_o   out  1      correctness of training entry
//  pred_en_o      out  1      fetch may use predictor output
//  busy_o         out  1      init sweep in progress
//  fifo_cnt_o     out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  commit_cnt_o   out  CNT_W  training entries written
//  mispred_cnt_o  out  CNT_W  training entries with md_correct_i=0
// BEHAVIOUR
//  Reset (rst_n low at an edge):
//   - state=INIT, sweep_cnt=0, FIFO empty, counters 0.
//   - All wr_* outputs 0; pred_en_o=0; busy_o=1; md_ready_o=0.
//  States: INIT, RUN; busy_o=(state==INIT), pred_en_o=(state==RUN), both from the state register.
//  INIT: each edge sets
//   - wr_valid_o=1, wr_init_o=1, wr_idx_o=sweep_cnt, wr_hist/pred/correct=0.
//   - sweep_cnt++; when sweep_cnt==TBL_DEPTH-1, state<=RUN.
//   - Writes idx 0..TBL_DEPTH-1 are visible in cycles 1..TBL_DEPTH after reset release.
//   - RUN begins in cycle TBL_DEPTH+1.
//  INIT: md_ready_o=0; no pushes, no pops; statistics hold.
//  RUN: md_ready_o = (fifo_cnt_o < FIFO_DEPTH); a full FIFO refuses a push even when a pop occurs in the same cycle.
//  RUN: accepted request pushed at edge t.
//   - At the next edge, if it is FIFO head, it is popped into wr_* with wr_valid_o=1, wr_init_o=0.
//   - Minimum latency: 2 edges from acceptance to write strobe.
//   - FIFO empty: wr_valid_o<=0 (other wr_* hold).
//   - Push and pop in one cycle: occupancy unchanged; strict FIFO order.
//  Statistics, on each RUN pop:
//   - commit_cnt_o++; mispred_cnt_o++ if entry correct=0.
//   - Both counters saturate at all-ones; cleared only by reset, not by flush.
//  flush_i at an edge (priority over push/pop, any state):
//   - state<=INIT, sweep_cnt<=0, FIFO emptied, wr_valid_o<=0 for that edge.
//   - Sweep idx 0 is issued on the following edge.
//   - A request presented with flush_i is dropped; md_ready_o is 0 in the cycle after flush.
//   - Flush during INIT restarts the sweep at 0.
//  Reset mid-sweep or mid-drain: identical to power-on reset; no partial writes issued.
//  Pointers wrap modulo FIFO_DEPTH; sweep_cnt never exceeds TBL_DEPTH-1.
// TESTING
//  Reset release -> wr_init_o=1 with idx 0..127 in cycles 1..128; pred_en_o=1, md_ready_o=1 at cycle 129.
//  One request (idx=5, hist=0x2A, pred=1, correct=0) at t -> wr_valid_o at t+2 with same fields; commit_cnt_o=1, mispred_cnt_o=1.
//  md_valid_i held high for 6 cycles, entries A..F, back-to-back pushes and pops -> 6 writes in order A..F; fifo_cnt_o never exceeds 1.
//  Hold drain by issuing 5 requests during the last init cycles -> md_ready_o=0; sweep unaffected, no request written during INIT.
//  flush_i with 3 entries buffered and md_valid_i high -> no training writes; sweep restarts at idx 0; counters unchanged.
//  Counters preset near all-ones (CNT_W=4 build), 20 mispredicted commits -> both counters stick at 4'hF.

Source files
------------

// File: rtl/bp_train_sched.sv
// Training-port scheduler for the global/local CBP predictor tables.
// After reset or flush it sweeps every table index with an init write.
// After the sweep it drains buffered commit-training requests onto the
// single table write port at one per cycle, and keeps commit/mispredict
// statistics.
//
// Handshake: a request transfers at a rising edge where md_valid_i and
// md_ready_o are both high and flush_i is low. md_ready_o depends only on
// registered state, never on md_valid_i. A producer may change its
// payload freely while md_ready_o is low.
module bp_train_sched #(
    parameter int IDX_W      = 7,
    parameter int TBL_DEPTH  = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          md_valid_i,
    output logic                          md_ready_o,
    input  logic [IDX_W-1:0]              md_idx_i,
    input  logic [IDX_W-1:0]              md_hist_i,
    input  logic                          md_pred_i,
    input  logic                          md_correct_i,
    output logic                          wr_valid_o,
    output logic                          wr_init_o,
    output logic [IDX_W-1:0]              wr_idx_o,
    output logic [IDX_W-1:0]              wr_hist_o,
    output logic                          wr_pred_o,
    output logic                          wr_correct_o,
    output logic                          pred_en_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic [CNT_W-1:0]              commit_cnt_o,
    output logic [CNT_W-1:0]              mispred_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = 2 * IDX_W + 2;
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(TBL_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [OCC_W-1:0]   cnt_q;
    logic               push, pop;
    logic [ENT_W-1:0]   head;

    logic               wr_valid_q, wr_init_q, wr_pred_q, wr_correct_q;
    logic [IDX_W-1:0]   wr_idx_q, wr_hist_q;
    logic [CNT_W-1:0]   commit_q, mispred_q;

    assign head          = mem_q[rd_ptr_q];
    assign md_ready_o    = (state_q == ST_RUN) && (cnt_q < OCC_FULL);
    assign busy_o        = (state_q == ST_INIT);
    assign pred_en_o     = (state_q == ST_RUN);
    assign fifo_cnt_o    = cnt_q;
    assign wr_valid_o    = wr_valid_q;
    assign wr_init_o     = wr_init_q;
    assign wr_idx_o      = wr_idx_q;
    assign wr_hist_o     = wr_hist_q;
    assign wr_pred_o     = wr_pred_q;
    assign wr_correct_o  = wr_correct_q;
    assign commit_cnt_o  = commit_q;
    assign mispred_cnt_o = mispred_q;

    // State register and sweep counter.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next state, sweep advance and FIFO push/pop decisions; flush wins.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (flush_i) begin
            state_d = ST_INIT;
            sweep_d = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (sweep_q == SWEEP_LAST) begin
                        state_d = ST_RUN;
                        sweep_d = '0;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Push uses pre-edge occupancy, so a full FIFO refuses
                    // even when it pops in the same cycle.
                    push = md_valid_i && md_ready_o;
                    pop  = (cnt_q != '0);
                end
                default: begin
                    state_d = ST_INIT;
                    sweep_d = '0;
                end
            endcase
        end
    end

    // FIFO payload storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {md_idx_i, md_hist_i, md_pred_i, md_correct_i};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk_i) begin
        if (!rst_n || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Registered table write port: init sweep, training pop, or idle.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_valid_q   <= 1'b0;
            wr_init_q    <= 1'b0;
            wr_idx_q     <= '0;
            wr_hist_q    <= '0;
            wr_pred_q    <= 1'b0;
            wr_correct_q <= 1'b0;
        end else if (flush_i) begin
            wr_valid_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            wr_valid_q   <= 1'b1;
            wr_init_q    <= 1'b1;
            wr_idx_q     <= sweep_q;
            wr_hist_q    <= '0;
            wr_pred_q    <= 1'b0;
            wr_correct_q <= 1'b0;
        end else if (pop) begin
            wr_valid_q <= 1'b1;
            wr_init_q  <= 1'b0;
            {wr_idx_q, wr_hist_q, wr_pred_q, wr_correct_q} <= head;
        end else begin
            wr_valid_q <= 1'b0;
        end
    end

    // Saturating statistics; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            commit_q  <= '0;
            mispred_q <= '0;
        end else if (pop) begin
            if (commit_q != CNT_MAX) commit_q <= commit_q + 1'b1;
            if (!head[0] && (mispred_q != CNT_MAX)) mispred_q <= mispred_q + 1'b1;
        end
    end

endmodule
